// File: rtl/bin2gray_counter.sv
// Binary up/down counter with registered Gray-code and binary outputs.
// Gray output is always derived from the next binary value, so both
// outputs update on the same edge and stay consistent.
module bin2gray_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ALL_ZERO = '0;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] bin_q,  bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;

  // Next-state: load beats count beats hold; wrap flags the roll-over edge only.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      if (up_dn) begin
        bin_d  = bin_q + ONE;
        wrap_d = (bin_q == ALL_ONES);
      end else begin
        bin_d  = bin_q - ONE;
        wrap_d = (bin_q == ALL_ZERO);
      end
    end
    gray_d = bin_d ^ (bin_d >> 1);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q  <= ALL_ZERO;
      gray_q <= ALL_ZERO;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  // Terminal count follows the live direction input.
  always_comb begin
    tc = up_dn ? (bin_q == ALL_ONES) : (bin_q == ALL_ZERO);
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_bin2gray_counter.sv
// Scoreboard bench for bin2gray_counter: driver queues hand-computed
// expectations, monitor checks outputs one clock after each stimulus.
module tb_bin2gray_counter;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         up_dn;
  logic         load;
  logic [W-1:0] load_bin;
  logic [W-1:0] gray_out;
  logic [W-1:0] bin_out;
  logic         tc;
  logic         wrap;

  typedef struct {
    int           id;
    logic [W-1:0] bin;
    logic [W-1:0] gray;
    logic         wrap;
    logic         tc;
    logic         onebit;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   vec_id   = 0;

  bin2gray_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_bin (load_bin),
    .gray_out (gray_out),
    .bin_out  (bin_out),
    .tc       (tc),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus on the falling edge and queue its expected result.
  task automatic step(input logic r, input logic ld, input logic [W-1:0] lb,
                      input logic e, input logic ud,
                      input logic [W-1:0] eb, input logic [W-1:0] eg,
                      input logic ew, input logic et, input logic ob);
    exp_t x;
    @(negedge clk);
    rst_n    = r;
    load     = ld;
    load_bin = lb;
    en       = e;
    up_dn    = ud;
    x.id = vec_id; x.bin = eb; x.gray = eg; x.wrap = ew; x.tc = et; x.onebit = ob;
    exp_q.push_back(x);
    vec_id++;
  endtask

  // Monitor: after each rising edge, pop one expectation and compare.
  logic [W-1:0] prev_gray;
  initial begin
    exp_t x;
    prev_gray = '0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        checks++;
        if (bin_out !== x.bin) begin
          failures++;
          $display("FAIL vec%0d bin_out got=%h exp=%h", x.id, bin_out, x.bin);
        end
        checks++;
        if (gray_out !== x.gray) begin
          failures++;
          $display("FAIL vec%0d gray_out got=%h exp=%h", x.id, gray_out, x.gray);
        end
        checks++;
        if (wrap !== x.wrap) begin
          failures++;
          $display("FAIL vec%0d wrap got=%b exp=%b", x.id, wrap, x.wrap);
        end
        checks++;
        if (tc !== x.tc) begin
          failures++;
          $display("FAIL vec%0d tc got=%b exp=%b", x.id, tc, x.tc);
        end
        checks++;
        if (gray_out !== (bin_out ^ (bin_out >> 1))) begin
          failures++;
          $display("FAIL vec%0d gray_invariant gray=%h bin=%h", x.id, gray_out, bin_out);
        end
        if (x.onebit) begin
          checks++;
          if ($countones(gray_out ^ prev_gray) != 1) begin
            failures++;
            $display("FAIL vec%0d gray_onebit prev=%h now=%h", x.id, prev_gray, gray_out);
          end
        end
        prev_gray = gray_out;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    logic [W-1:0] gtab [16];
    logic [W-1:0] b;
    gtab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
             4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    rst_n = 1'b0; load = 1'b0; load_bin = '0; en = 1'b0; up_dn = 1'b1;

    // Reset for two edges, then idle in both directions.
    step(0, 0, 4'h0, 0, 1, 4'h0, 4'h0, 0, 0, 0);
    step(0, 0, 4'h0, 0, 1, 4'h0, 4'h0, 0, 0, 0);
    step(1, 0, 4'h0, 0, 1, 4'h0, 4'h0, 0, 0, 0);
    step(1, 0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 1, 0);

    // Full up count 0 -> F -> 0.
    for (int i = 1; i <= 16; i++) begin
      b = W'(i % 16);
      step(1, 0, 4'h0, 1, 1, b, gtab[i % 16], (i == 16), (b == 4'hF), 1);
    end

    // Down from 0 wraps to F.
    step(1, 0, 4'h0, 1, 0, 4'hF, 4'h8, 1, 0, 1);
    step(1, 0, 4'h0, 1, 0, 4'hE, 4'h9, 0, 0, 1);

    // Load beats enable, then counting resumes.
    step(1, 1, 4'hA, 1, 0, 4'hA, 4'hF, 0, 0, 0);
    step(1, 0, 4'h0, 1, 1, 4'hB, 4'hE, 0, 0, 1);

    // Reach 5, hold three edges, flip direction.
    step(1, 1, 4'h4, 0, 1, 4'h4, 4'h6, 0, 0, 0);
    step(1, 0, 4'h0, 1, 1, 4'h5, 4'h7, 0, 0, 1);
    step(1, 0, 4'h0, 0, 1, 4'h5, 4'h7, 0, 0, 0);
    step(1, 0, 4'h0, 0, 1, 4'h5, 4'h7, 0, 0, 0);
    step(1, 0, 4'h0, 0, 1, 4'h5, 4'h7, 0, 0, 0);
    step(1, 0, 4'h0, 1, 0, 4'h4, 4'h6, 0, 0, 1);
    step(1, 0, 4'h0, 1, 0, 4'h3, 4'h2, 0, 0, 1);

    // Load equal to current value.
    step(1, 1, 4'h3, 1, 0, 4'h3, 4'h2, 0, 0, 0);

    // Load F, wrap up, wrap pulse clears on hold.
    step(1, 1, 4'hF, 0, 1, 4'hF, 4'h8, 0, 1, 0);
    step(1, 0, 4'h0, 1, 1, 4'h0, 4'h0, 1, 0, 1);
    step(1, 0, 4'h0, 0, 1, 4'h0, 4'h0, 0, 0, 0);

    // Reset mid-count beats load.
    step(1, 1, 4'h9, 0, 1, 4'h9, 4'hD, 0, 0, 0);
    step(0, 1, 4'h3, 1, 1, 4'h0, 4'h0, 0, 0, 0);
    step(1, 0, 4'h0, 1, 1, 4'h1, 4'h1, 0, 0, 1);

    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bin2gray_counter.md
Name: bin2gray_counter

Overview:
- Sequential binary-to-Gray encoder and counter; the encode-side companion to the team's Gray-to-binary decoder.
- Holds an internal binary count that can be loaded, counted up or counted down.
- Presents the count as a registered Gray code, with its binary mirror, so downstream logic and the decoder can consume glitch-free, single-bit-change values.
- Used as a Gray-coded pointer/position source in the experiment designs.

Parameters:
- WIDTH, 4, bit width of count, Gray output and binary output (min 2).

Ports:
- clk        input   1      rising-edge clock; sole clock of the block
- rst_n      input   1      synchronous, active-low reset
- en         input   1      count enable; one step per cycle while high
- up_dn      input   1      direction: 1 = increment, 0 = decrement
- load       input   1      load request; overrides en
- load_bin   input   WIDTH  binary value captured on load
- gray_out   output  WIDTH  registered Gray code of current count
- bin_out    output  WIDTH  registered binary count
- tc         output  1      terminal count, combinational from bin_out and up_dn
- wrap       output  1      registered one-cycle pulse on roll-over

Behaviour:
- Reset: synchronous only.
  - On a rising clk edge with rst_n=0: bin_out=0, gray_out=0, wrap=0.
  - tc then reflects up_dn: it reads 0 for up, 1 for down.
  - rst_n has priority over load and en.
- Priority on each rising edge with rst_n=1: load > en > hold.
- Load:
  - bin_out <= load_bin and gray_out <= load_bin ^ (load_bin >> 1), on the same edge.
  - wrap <= 0.
  - up_dn is ignored.
- Count (en=1, load=0):
  - bin_next = bin_out + 1 (up_dn=1) or bin_out - 1 (up_dn=0), modulo 2^WIDTH.
  - gray_out <= bin_next ^ (bin_next >> 1).
  - gray_out is computed from the next binary value, never from the previous gray_out, so gray_out and bin_out always change on the same edge.
- Hold (en=0, load=0): bin_out and gray_out unchanged; wrap <= 0.
- Latency: one clock from load/en sample to updated outputs. No combinational path from any input to gray_out or bin_out.
- Wrap-around:
  - Up from all-ones gives 0. Down from 0 gives all-ones.
  - The edge that performs the roll-over sets wrap=1 for exactly one cycle. Any other edge clears it.
- tc: 1 when (up_dn=1 and bin_out == all-ones) or (up_dn=0 and bin_out == 0). It is combinational and follows up_dn changes within the same cycle.
- Invariants:
  - gray_out == bin_out ^ (bin_out >> 1) at all times after the first reset.
  - Consecutive enabled count steps (no load) change exactly one bit of gray_out, including across wrap.
- Direction change mid-count: takes effect on the next enabled edge; no bubble, no extra step.
- Reset mid-count: the count is discarded on that edge. Counting restarts from 0 on the first enabled edge after rst_n returns high.
- Load while en=1: load wins, and the loaded value is presented for at least one cycle before counting resumes.
- Load with value equal to the current count: outputs unchanged, wrap=0.
- X handling: before the first reset edge, outputs are undefined. The bench must reset first.

Test Plan:
- Reset with WIDTH=4: rst_n=0 for 2 edges, then en=0 -> gray_out=0000, bin_out=0000, wrap=0; tc=0 with up_dn=1, tc=1 with up_dn=0.
- Up count, en=1, up_dn=1, 16 edges from 0 -> gray_out sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0 (hex).
  - tc=1 while bin_out=F.
  - wrap=1 only in the cycle after F→0.
  - Every step differs in exactly one bit.
- Down count from 0, up_dn=0, en=1, 1 edge -> bin_out=F, gray_out=8, wrap=1.
  - Next edge: bin_out=E, gray_out=9, wrap=0.
- Load 0xA with en=1 -> after edge, bin_out=A, gray_out=F, wrap=0.
  - Next edge (load=0, up_dn=1): bin_out=B, gray_out=E.
- Hold and direction flip: count to bin 5 (gray 7), en=0 for 3 edges -> outputs stay at 5/7.
  - Then up_dn=0, en=1 -> 4/6, then 3/2.
- Reset mid-count: at bin 9, assert rst_n=0 with load=1, load_bin=3 -> after edge, outputs 0/0, wrap=0 (reset beats load).
  - After release with en=1: 1/1.
